key_load_ctrl: RTL and testbench
================================

KEY_LOAD_CTRL -- requirements
Module: key_load_ctrl

Interface
REQ-001 The block SHALL have parameter KEY_W, default 8, giving the key width in bits (range 2..32).
REQ-002 The block SHALL have parameter MAX_TRIES, default 3, giving the number of failed load attempts allowed before lockout (range 1..7).
REQ-003 The block SHALL have parameter TIMEOUT, default 15, giving the number of cycles to wait for mem_ack before an attempt fails (range 1..255).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  single-cycle pulse that begins a load; sampled only in IDLE.
REQ-007 mem_req  output  1  key-store read request, held until acknowledged or timed out.
REQ-008 mem_addr  output  $clog2(KEY_W+1)  index of the bit requested; 0..KEY_W-1 are key bits, KEY_W is the parity bit.
REQ-009 mem_ack  input  1  key-store acknowledge; mem_data is valid in the same cycle.
REQ-010 mem_data  input  1  requested bit.
REQ-011 key_out  output  KEY_W  key applied to the protected FSM (keyinput bus).
REQ-012 core_rst  output  1  reset to the protected FSM; high whenever the state is not RUN.
REQ-013 ready  output  1  high in RUN only.
REQ-014 lockout  output  1  high in LOCK only.
REQ-015 tries  output  3  count of failed attempts since reset.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, CHECK, RUN, FAIL and LOCK.
REQ-017 IDLE: on start, the block SHALL clear the shift register and the bit index, reset the timer, and go to FETCH on the next cycle.
REQ-018 FETCH: mem_req SHALL be high and mem_addr SHALL equal the bit index; the timer SHALL increment each cycle that mem_ack is low.
REQ-019 FETCH, mem_ack high: mem_data SHALL shift into key bit [index], the index SHALL increment, and the timer SHALL clear.
- If the index was KEY_W, mem_data SHALL be stored as the parity bit instead and the state SHALL go to CHECK.
- mem_req SHALL drop for exactly one cycle after each ack; no back-to-back requests.
REQ-020 FETCH, timer reaching TIMEOUT with no ack SHALL go to FAIL; an ack in the same cycle the timeout is reached SHALL win.
REQ-021 CHECK, one cycle: if the XOR of the key bits equals the parity bit, key_out SHALL load the shift register and the state SHALL go to RUN; otherwise the state SHALL go to FAIL.
REQ-022 FAIL, one cycle: tries SHALL increment, saturating at 7; if the new value is at least MAX_TRIES the state SHALL go to LOCK, else to IDLE.
REQ-023 RUN: core_rst SHALL be low and key_out SHALL be held; start SHALL be ignored; the block SHALL stay in RUN until rst.
REQ-024 LOCK SHALL be terminal until rst: key_out SHALL be all-zero, core_rst SHALL be high, and start SHALL be ignored.
REQ-025 key_out SHALL change only on the CHECK-to-RUN transition and on reset; partially shifted bits SHALL never reach key_out.
REQ-026 An ack arriving outside FETCH SHALL be ignored.
REQ-027 Latency from start to ready for a zero-wait-state store that acks in the cycle after req SHALL be exactly 2*(KEY_W+1)+2 cycles.

Reset
REQ-028 rst high SHALL asynchronously force the following values: state IDLE, key_out 0, core_rst 1, ready 0, lockout 0, mem_req 0, mem_addr 0, tries 0, timer 0, index 0.
REQ-029 rst asserted mid-FETCH SHALL abort the load at once, with mem_req low in the same cycle; the first rising edge after rst falls SHALL see IDLE.

Verification
REQ-030 KEY_W=8, key 8'hA5, parity 0, immediate acks -> ready high 20 cycles after start, key_out=8'hA5, core_rst low, tries=0.
REQ-031 Key 8'hA5 with parity 1 -> FAIL, tries=1, back to IDLE, key_out stays 0; a second start with correct parity -> RUN.
REQ-032 mem_ack withheld at bit 3 -> mem_req high for 15 cycles, then FAIL and tries increments; three such attempts -> lockout=1, and a further start -> no mem_req.
REQ-033 rst pulsed while mem_addr=5 -> mem_req and all outputs return to reset values at once; a fresh start -> mem_addr begins at 0.
REQ-034 An ack in the same cycle the timer reaches TIMEOUT -> the bit is accepted and there is no FAIL; a spurious ack in IDLE or RUN -> no state or output change.

Source files
------------

// File: rtl/key_load_ctrl.sv
// key_load_ctrl: fetches a KEY_W-bit key plus one parity bit from a
// bit-serial key store, checks the parity, and only then applies the key
// to the protected FSM and releases its reset. Failed attempts (store
// timeout or bad parity) are counted; reaching MAX_TRIES locks the block
// until the next reset.
module key_load_ctrl #(
    parameter int KEY_W     = 8,   // key width in bits, 2..32
    parameter int MAX_TRIES = 3,   // failed attempts before lockout, 1..7
    parameter int TIMEOUT   = 15   // request cycles to wait for mem_ack, 1..255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         mem_req,
    output logic [$clog2(KEY_W+1)-1:0]   mem_addr,
    input  logic                         mem_ack,
    input  logic                         mem_data,
    output logic [KEY_W-1:0]             key_out,
    output logic                         core_rst,
    output logic                         ready,
    output logic                         lockout,
    output logic [2:0]                   tries
);

    localparam int              AW         = $clog2(KEY_W + 1);
    // Address KEY_W carries the parity bit rather than a key bit.
    localparam logic [AW-1:0]   PAR_IDX    = AW'(KEY_W);
    // Timer value on the last request cycle before the attempt times out.
    localparam logic [7:0]      TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0]      TRY_LIMIT  = 3'(MAX_TRIES);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CHECK,
        RUN,
        FAIL,
        LOCK
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [AW-1:0]     idx;        // bit currently being requested
    logic [7:0]        timer;      // request cycles spent waiting for this bit
    logic              gap;        // forces mem_req low for one cycle
    logic [KEY_W-1:0]  shreg;      // key bits gathered so far
    logic              parity;     // parity bit read from the store
    logic [KEY_W-1:0]  key_reg;    // key presented to the protected FSM
    logic [2:0]        tries_reg;

    // Control strobes from the FSM to the datapath registers.
    logic              load_clear; // start accepted: clear index, timer, key
    logic              accept;     // store acknowledged the current bit
    logic              tick;       // request cycle without acknowledge
    logic              key_load;   // parity good: copy key to key_out
    logic              tries_inc;  // one more failed attempt
    logic [2:0]        tries_new;  // saturating increment of tries

    assign tries_new = (tries_reg == 3'd7) ? 3'd7 : tries_reg + 3'd1;

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic, datapath strobes and state-decoded outputs.
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        load_clear = 1'b0;
        accept     = 1'b0;
        tick       = 1'b0;
        key_load   = 1'b0;
        tries_inc  = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        core_rst   = 1'b1;
        ready      = 1'b0;
        lockout    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    load_clear = 1'b1;
                    next_state = FETCH;
                end
            end

            FETCH: begin
                mem_addr = idx;
                // Acks during the gap cycle are not answers to a request.
                if (!gap) begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        // An ack on the final allowed cycle still counts.
                        accept = 1'b1;
                        if (idx == PAR_IDX) begin
                            next_state = CHECK;
                        end
                    end else if (timer == TIMER_LAST) begin
                        next_state = FAIL;
                    end else begin
                        tick = 1'b1;
                    end
                end
            end

            CHECK: begin
                if ((^shreg) == parity) begin
                    key_load   = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = FAIL;
                end
            end

            FAIL: begin
                tries_inc  = 1'b1;
                next_state = (tries_new >= TRY_LIMIT) ? LOCK : IDLE;
            end

            RUN: begin
                core_rst = 1'b0;
                ready    = 1'b1;
            end

            LOCK: begin
                lockout = 1'b1;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Bit index, wait timer and the one-cycle request gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            timer <= '0;
            gap   <= 1'b0;
        end else begin
            if (load_clear) begin
                idx   <= '0;
                timer <= '0;
                gap   <= 1'b1;
            end else if (accept) begin
                // The parity address is the last one; never step past it.
                if (idx != PAR_IDX) begin
                    idx <= idx + 1'b1;
                end
                timer <= '0;
                gap   <= 1'b1;
            end else begin
                if (tick) begin
                    timer <= timer + 8'd1;
                end
                if (state == FETCH) begin
                    gap <= 1'b0;
                end
            end
        end
    end

    // Shift register for the key bits and the separately held parity bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg  <= '0;
            parity <= 1'b0;
        end else if (load_clear) begin
            shreg  <= '0;
            parity <= 1'b0;
        end else if (accept) begin
            if (idx == PAR_IDX) begin
                parity <= mem_data;
            end else begin
                for (int b = 0; b < KEY_W; b++) begin
                    if (idx == AW'(b)) begin
                        shreg[b] <= mem_data;
                    end
                end
            end
        end
    end

    // Applied key: written only when a checked key enters RUN, so partial
    // keys never leak out. LOCK is unreachable from RUN, so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_reg <= '0;
        end else if (key_load) begin
            key_reg <= shreg;
        end
    end

    // Failed-attempt counter, saturating at 7.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tries_reg <= 3'd0;
        end else if (tries_inc) begin
            tries_reg <= tries_new;
        end
    end

    assign key_out = key_reg;
    assign tries   = tries_reg;

endmodule

// File: tb/tb_key_load_ctrl.sv
// tb_key_load_ctrl: randomized scoreboard bench for key_load_ctrl. The
// stimulus side plays the key store and predicts, from the acknowledge
// schedule, when and how the visible outputs next change; a monitor pops
// those predictions whenever the outputs change.
module tb_key_load_ctrl;

    localparam int KEY_W     = 8;
    localparam int MAX_TRIES = 3;
    localparam int TIMEOUT   = 15;
    localparam int AW        = $clog2(KEY_W + 1);
    localparam int NEVER     = 1000;   // wait value meaning "never ack"

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              mem_ack = 1'b0;
    logic              mem_data = 1'b0;
    logic              mem_req;
    logic [AW-1:0]     mem_addr;
    logic [KEY_W-1:0]  key_out;
    logic              core_rst;
    logic              ready;
    logic              lockout;
    logic [2:0]        tries;

    key_load_ctrl #(
        .KEY_W     (KEY_W),
        .MAX_TRIES (MAX_TRIES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .key_out  (key_out),
        .core_rst (core_rst),
        .ready    (ready),
        .lockout  (lockout),
        .tries    (tries)
    );

    always #5 clk = ~clk;

    // One predicted output change: cycles from the start cycle, new values.
    typedef struct {
        int               lat;
        logic             ready;
        logic             lockout;
        logic             core_rst;
        logic [2:0]       tries;
        logic [KEY_W-1:0] key;
    } ev_t;

    ev_t exp_q[$];

    int n_chk     = 0;
    int n_pass    = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int rst_gen   = 0;

    // Store behaviour per bit: request cycles before the ack (>= TIMEOUT: none).
    int w_sched[KEY_W+1];

    // Reference model state.
    int tries_m   = 0;
    bit running_m = 1'b0;
    bit locked_m  = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: any change of the visible outputs must match the next prediction.
    initial begin
        ev_t                e;
        logic [KEY_W+5:0]   obs;
        logic [KEY_W+5:0]   prev_obs;
        int                 seen_gen;
        prev_obs = '0;
        seen_gen = 0;
        forever begin
            @(negedge clk);
            obs = {ready, lockout, core_rst, tries, key_out};
            if (rst || seen_gen != rst_gen) begin
                seen_gen = rst_gen;
                prev_obs = obs;
            end else if (obs != prev_obs) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output_change", obs, prev_obs);
                end else begin
                    e = exp_q.pop_front();
                    check("event_latency", cyc - start_cyc, e.lat);
                    check("ev_ready", ready, e.ready);
                    check("ev_lockout", lockout, e.lockout);
                    check("ev_core_rst", core_rst, e.core_rst);
                    check("ev_tries", tries, e.tries);
                    check("ev_key_out", key_out, e.key);
                end
                prev_obs = obs;
            end
        end
    end

    // Asynchronous reset pulse inside one clock phase; called just after a negedge.
    task automatic pulse_reset();
        #1;
        rst     = 1'b1;
        mem_ack = 1'b0;
        start   = 1'b0;
        #1;
        check("rst_key_out", key_out, 0);
        check("rst_core_rst", core_rst, 1);
        check("rst_ready", ready, 0);
        check("rst_lockout", lockout, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_tries", tries, 0);
        #1;
        rst = 1'b0;
        rst_gen++;
        tries_m   = 0;
        running_m = 1'b0;
        locked_m  = 1'b0;
    endtask

    task automatic set_waits_zero();
        for (int i = 0; i <= KEY_W; i++) begin
            w_sched[i] = 0;
        end
    endtask

    task automatic set_waits_random();
        for (int i = 0; i <= KEY_W; i++) begin
            case ($urandom_range(0, 11))
                0:       w_sched[i] = NEVER;
                1, 2:    w_sched[i] = TIMEOUT - 1;
                default: w_sched[i] = $urandom_range(0, 3);
            endcase
        end
    endtask

    // One load attempt: predict the outcome, then play the store.
    task automatic run_attempt(input logic [KEY_W-1:0] key, input logic par);
        ev_t e;
        int  prior;
        int  tj;
        bit  ignored;
        int  bit_i;
        int  rc;
        bit  done;

        ignored = running_m || locked_m;
        if (!ignored) begin
            // Each bit costs one gap cycle plus (wait+1) request cycles.
            prior = 0;
            tj    = -1;
            for (int i = 0; i <= KEY_W; i++) begin
                if (tj < 0) begin
                    if (w_sched[i] >= TIMEOUT) begin
                        tj = i;
                    end else begin
                        prior += 2 + w_sched[i];
                    end
                end
            end
            if (tj < 0 && (^key) == par) begin
                e.lat      = prior + 2;
                e.ready    = 1'b1;
                e.lockout  = 1'b0;
                e.core_rst = 1'b0;
                e.tries    = 3'(tries_m);
                e.key      = key;
                running_m  = 1'b1;
            end else begin
                e.lat      = (tj >= 0) ? prior + TIMEOUT + 3 : prior + 3;
                tries_m    = (tries_m < 7) ? tries_m + 1 : 7;
                locked_m   = (tries_m >= MAX_TRIES);
                e.ready    = 1'b0;
                e.lockout  = locked_m;
                e.core_rst = 1'b1;
                e.tries    = 3'(tries_m);
                e.key      = '0;
            end
            exp_q.push_back(e);
        end

        @(negedge clk);
        start     = 1'b1;
        mem_ack   = 1'b0;
        start_cyc = cyc;
        bit_i = 0;
        rc    = 0;
        done  = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            start    = 1'b0;
            mem_ack  = 1'b0;
            mem_data = 1'($urandom);
            if (ignored) begin
                mem_ack = 1'($urandom);
                check("no_req_after_ignored_start", mem_req, 0);
                if (c == 19) begin
                    done = 1'b1;
                end
            end else if (mem_req) begin
                if (rc == w_sched[bit_i]) begin
                    check("mem_addr", mem_addr, bit_i);
                    mem_ack  = 1'b1;
                    mem_data = (bit_i == KEY_W) ? par : key[bit_i];
                    bit_i++;
                    rc = 0;
                    if (bit_i > KEY_W) begin
                        done = 1'b1;
                    end
                end else begin
                    rc++;
                end
            end else if (rc != 0) begin
                check("req_cycles_before_timeout", rc, TIMEOUT);
                done = 1'b1;
            end
        end
        if (!done) begin
            check("attempt_finished", 0, 1);
        end

        // Let the predicted change appear while sprinkling ignored acks.
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            mem_ack  = 1'($urandom);
            mem_data = 1'($urandom);
        end
        if (exp_q.size() != 0) begin
            check("predicted_event_seen", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (3) begin
            @(negedge clk);
            mem_ack  = 1'($urandom);
            mem_data = 1'($urandom);
        end
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    // Start a load with immediate acks and reset it while bit 5 is requested.
    task automatic abort_at_bit5();
        bit found;
        found = 1'b0;
        @(negedge clk);
        start     = 1'b1;
        start_cyc = cyc;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            start   = 1'b0;
            mem_ack = 1'b0;
            if (mem_req) begin
                if (mem_addr == AW'(5)) begin
                    found = 1'b1;
                end else begin
                    mem_ack  = 1'b1;
                    mem_data = 1'($urandom);
                end
            end
        end
        check("reached_addr5", found, 1);
        pulse_reset();
    endtask

    initial begin
        @(negedge clk);
        pulse_reset();

        // Good key with wrong parity, then the same key correctly: 20-cycle load.
        set_waits_zero();
        run_attempt(8'hA5, 1'b1);
        run_attempt(8'hA5, 1'b0);
        // start and acks in RUN are ignored
        run_attempt(8'h3C, 1'b0);

        // Ack arrives on the very cycle the timer would expire.
        @(negedge clk);
        pulse_reset();
        set_waits_zero();
        w_sched[2] = TIMEOUT - 1;
        run_attempt(8'h5A, 1'b0);

        // Reset in the middle of a fetch, then a fresh load from address 0.
        @(negedge clk);
        pulse_reset();
        abort_at_bit5();
        set_waits_zero();
        run_attempt(8'hC3, 1'b1);

        // Store never answers bit 3: three timeouts lock the block.
        @(negedge clk);
        pulse_reset();
        set_waits_zero();
        w_sched[3] = NEVER;
        repeat (3) run_attempt(8'h96, 1'b0);
        set_waits_zero();
        run_attempt(8'h96, 1'b0);

        // Randomized loads against the model.
        for (int k = 0; k < 10; k++) begin
            logic [KEY_W-1:0] key;
            logic             par;
            if (running_m || locked_m) begin
                @(negedge clk);
                pulse_reset();
            end
            key = KEY_W'($urandom);
            par = ($urandom_range(0, 3) == 0) ? ~(^key) : (^key);
            set_waits_random();
            run_attempt(key, par);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
